// File: rtl/mult_job_sequencer.sv
// Front-end sequencer for a start/ready multiplier.
// Operand pairs are buffered in a small FIFO and issued one at a time. Each job
// gets a single-cycle start pulse. The product is captured into a one-entry
// output slot when the multiplier completes. Results leave in input order.
`timescale 1ns/1ps
module mult_job_sequencer #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0]           in_a,
  input  logic [N-1:0]           in_b,
  output logic                   mul_start,
  output logic [N-1:0]           mul_a,
  output logic [N-1:0]           mul_b,
  input  logic                   mul_ready,
  input  logic [2*N-1:0]         mul_product,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*N-1:0]         out_product,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
  } job_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ARM   = 2'd2,
    WAIT  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Operand FIFO
  // ---------------------------------------------------------------------------
  job_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;

  // Fullness alone decides acceptance. A same-cycle pop does not open a slot.
  assign in_ready   = (count != FULL);
  assign push       = in_valid && in_ready;
  assign fifo_count = count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array is data only, so it needs no reset. Stale entries are never
  // read because the count is cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a: in_a, b: in_b};
  end

  // ---------------------------------------------------------------------------
  // Job FSM
  // ---------------------------------------------------------------------------
  state_t state, state_nxt;
  logic   capture;
  logic   slot_free;

  // The output slot can take a new result if it is empty now.
  // It can also take one if it is being drained on this same edge.
  assign slot_free = !out_valid || out_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and the pop/capture strobes
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = ARM;
      // After the start pulse, mul_ready may still show the previous job's
      // "done" level. Wait until the multiplier has actually dropped it.
      ARM: begin
        if (!mul_ready) state_nxt = WAIT;
      end
      // Completion is held back while the slot is occupied. The multiplier
      // keeps its product stable meanwhile, because no new start is issued.
      WAIT: begin
        if (mul_ready && slot_free) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The start pulse is decoded from registered state, so it is glitch-free and exactly one cycle.
  assign mul_start = (state == ISSUE);
  assign busy      = (state != IDLE) || out_valid;

  // Operands are loaded at pop. They are held through the job until the next pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a <= '0;
      mul_b <= '0;
    end else if (pop) begin
      mul_a <= mem[rd_ptr].a;
      mul_b <= mem[rd_ptr].b;
    end
  end

  // ---------------------------------------------------------------------------
  // Output slot
  // ---------------------------------------------------------------------------
  // Capture takes priority over drain, so a simultaneous drain and capture
  // leaves out_valid set with the new product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_product <= '0;
    end else if (capture) begin
      out_valid   <= 1'b1;
      out_product <= mul_product;
    end else if (out_valid && out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Bench for mult_job_sequencer. It uses a behavioural start/ready multiplier
// with N+1 cycles of latency and a queue scoreboard of expected a*b products.
`timescale 1ns/1ps
module tb_mult_job_sequencer;
  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid, in_ready;
  logic [N-1:0]    in_a, in_b;
  logic            mul_start;
  logic [N-1:0]    mul_a, mul_b;
  logic            mul_ready;
  logic [2*N-1:0]  mul_product;
  logic            out_valid, out_ready;
  logic [2*N-1:0]  out_product;
  logic [CW-1:0]   fifo_count;
  logic            busy;

  int total = 0;
  int bad   = 0;

  mult_job_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_ready(mul_ready), .mul_product(mul_product),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .fifo_count(fifo_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Behavioural multiplier. On start it drops ready for N+1 cycles. Ready then
  // rises with the product, which is held until the next start.
  logic [N-1:0] m_a, m_b;
  int           m_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_ready   <= 1'b1;
      mul_product <= '0;
      m_a <= '0; m_b <= '0; m_cnt <= 0;
    end else if (mul_start) begin
      mul_ready <= 1'b0;
      m_a <= mul_a; m_b <= mul_b; m_cnt <= N;
    end else if (!mul_ready) begin
      if (m_cnt == 0) begin
        mul_ready   <= 1'b1;
        mul_product <= (2*N)'(m_a) * (2*N)'(m_b);
      end else m_cnt <= m_cnt - 1;
    end
  end

  // Scoreboard and protocol monitor. Inputs change only at negedge or just
  // after posedge, so values read here are the ones that settled before the edge.
  logic [2*N-1:0] exp_q[$];
  int             n_out = 0, n_start = 0;
  logic           hold_v, prev_start;
  logic [2*N-1:0] hold_p;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      hold_v <= 1'b0; hold_p <= '0; prev_start <= 1'b0;
    end else begin
      if (mul_start) begin
        n_start <= n_start + 1;
        chk("start_while_mul_busy", 64'(mul_ready), 64'(1));
        chk("start_pulse_width", 64'(prev_start), 64'(0));
      end
      prev_start <= mul_start;
      if (!mul_ready) begin
        chk("mul_a_held", 64'(mul_a), 64'(m_a));
        chk("mul_b_held", 64'(mul_b), 64'(m_b));
      end
      if (in_valid && in_ready) exp_q.push_back((2*N)'(in_a) * (2*N)'(in_b));
      if (hold_v) begin
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_value", 64'(out_product), 64'(hold_p));
      end
      hold_v <= out_valid && !out_ready;
      hold_p <= out_product;
      if (out_valid && out_ready) begin
        n_out <= n_out + 1;
        chk("result_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) chk("result_order", 64'(out_product), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic push(input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b;
    for (int i = 0; i < 2000; i++) begin
      if (in_ready) break;
      @(negedge clk);
    end
    chk("push_accepted", 64'(in_ready), 64'(1));
    if (in_ready) @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk(tag, 64'(out_valid), 64'(1));
  endtask

  // Wait for a result, check it, then drain it with a one-cycle out_ready.
  task automatic take(input string tag, input logic [2*N-1:0] exp_v);
    wait_valid({tag, "_valid"});
    chk(tag, 64'(out_product), 64'(exp_v));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [N-1:0] t3a [7] = '{8'h03, 8'h10, 8'h7F, 8'h22, 8'h05, 8'hC0, 8'h09};
  logic [N-1:0] t3b [7] = '{8'h04, 8'h10, 8'h02, 8'h33, 8'hFF, 8'h03, 8'h09};

  initial begin
    int s0, s_out;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;

    // 1: reset values, then quiet after release
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_product", 64'(out_product), 64'(0));
    chk("rst_fifo_count", 64'(fifo_count), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_mul_start", 64'(mul_start), 64'(0));
    chk("rst_mul_ab", 64'({mul_a, mul_b}), 64'(0));
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_no_start", 64'(n_start), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_in_ready", 64'(in_ready), 64'(1));

    // 2: single job
    s0 = n_start;
    push(8'h0F, 8'h11);
    wait_valid("t2_valid");
    chk("t2_one_start", 64'(n_start - s0), 64'(1));
    take("t2_product", 16'h00FF);
    chk("t2_idle_after", 64'(busy), 64'(0));

    // 3: backpressure fills slot, WAIT and FIFO; job7 stalls until drain
    s_out = n_out;
    for (int j = 0; j < 6; j++) push(t3a[j], t3b[j]);
    repeat (25) @(negedge clk);
    chk("t3_fifo_full", 64'(fifo_count), 64'(4));
    chk("t3_in_ready_low", 64'(in_ready), 64'(0));
    chk("t3_slot_job1", 64'(out_product), 64'(16'h000C));
    chk("t3_busy", 64'(busy), 64'(1));
    in_valid = 1'b1; in_a = t3a[6]; in_b = t3b[6];
    repeat (3) @(negedge clk);
    chk("t3_job7_stalled", 64'(in_ready), 64'(0));
    chk("t3_no_early_out", 64'(n_out - s_out), 64'(0));
    out_ready = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (in_ready) break;
      @(negedge clk);
    end
    chk("t3_job7_accept", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if ((n_out - s_out) == 7 && !busy) break;
    end
    out_ready = 1'b0;
    chk("t3_count", 64'(n_out - s_out), 64'(7));
    chk("t3_drained", 64'(exp_q.size()), 64'(0));

    // 4: corner operands and hold stability
    push(8'hFF, 8'hFF);
    push(8'h00, 8'hA5);
    push(8'h01, 8'h80);
    wait_valid("t4_first_valid");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_stable", 64'(out_product), 64'(16'hFE01));
    end
    take("t4_ffxff", 16'hFE01);
    take("t4_zero", 16'h0000);
    take("t4_one", 16'h0080);

    // 5: reset with a job in WAIT and two queued
    push(8'h0B, 8'h0D);
    push(8'h16, 8'h07);
    push(8'h09, 8'h09);
    push(8'h04, 8'h04);
    repeat (40) @(negedge clk);
    chk("t5_queued", 64'(fifo_count), 64'(2));
    chk("t5_slot_full", 64'(out_valid), 64'(1));
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 64'(out_valid), 64'(0));
    chk("t5_rst_count", 64'(fifo_count), 64'(0));
    chk("t5_rst_busy", 64'(busy), 64'(0));
    chk("t5_rst_product", 64'(out_product), 64'(0));
    chk("t5_rst_mul_ab", 64'({mul_a, mul_b}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    push(8'h03, 8'h05);
    take("t5_after_rst", 16'h000F);
    repeat (30) @(negedge clk);
    chk("t5_no_ghost", 64'(out_valid), 64'(0));

    // 6: random traffic
    s_out = n_out;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          push(8'($urandom), 8'($urandom));
        end
      end
      begin
        for (int c = 0; c < 30000; c++) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
          if ((n_out - s_out) >= 200) break;
        end
        out_ready = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    chk("t6_count", 64'(n_out - s_out), 64'(200));
    chk("t6_no_leftover", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
